// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read RAM between the IF and MEM ports,
// and routes each read response back to the port that issued it.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_wen,
    input  logic [31:0]       mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [31:0]       mem_rdata,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_wen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [2:0]        starve_cnt_o
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP_IF  = 2'd1,
        RESP_MEM = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [31:0]       if_hold_q, if_hold_d;
    logic [31:0]       mem_hold_q, mem_hold_d;
    logic              starve_hit;

    assign starve_hit   = (STARVE_LIMIT != 0) && (starve_q == LIMIT);
    assign starve_cnt_o = starve_q;

    // Grant selection and RAM drive from the winner
    always_comb begin
        if_gnt    = if_req && (!mem_req || starve_hit);
        mem_gnt   = mem_req && !if_gnt;
        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_wen   = '0;
        ram_wdata = '0;
        if (if_gnt) begin
            ram_en   = 1'b1;
            ram_addr = if_addr;
        end else if (mem_gnt) begin
            ram_en    = 1'b1;
            ram_addr  = mem_addr;
            ram_wen   = mem_wen;
            ram_wdata = mem_wdata;
        end
    end

    // Counts consecutive denied IF cycles, saturating at the limit
    always_comb begin
        starve_d = '0;
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            if_hold_q  <= '0;
            mem_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if_hold_q  <= if_hold_d;
            mem_hold_q <= mem_hold_d;
        end
    end

    // Records which port owns the read that returns next cycle
    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = RESP_IF;
        end else if (mem_gnt && (mem_wen == 4'b0000)) begin
            state_d = RESP_MEM;
        end
    end

    // A cancelled fetch leaves both the IF output and its hold register untouched
    always_comb begin
        if_rvalid  = 1'b0;
        if_rdata   = if_hold_q;
        if_hold_d  = if_hold_q;
        mem_rvalid = 1'b0;
        mem_rdata  = mem_hold_q;
        mem_hold_d = mem_hold_q;
        unique case (state_q)
            RESP_IF: begin
                if (!if_cancel) begin
                    if_rvalid = 1'b1;
                    if_rdata  = ram_rdata;
                    if_hold_d = ram_rdata;
                end
            end
            RESP_MEM: begin
                mem_rvalid = 1'b1;
                mem_rdata  = ram_rdata;
                mem_hold_d = ram_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed scoreboard bench for mem_port_arbiter with a RAM model
// and a reference memory image kept by the bench.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int LIMIT = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              if_req, if_cancel, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              mem_req, mem_gnt, mem_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wen;
    logic [31:0]       mem_wdata, mem_rdata;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [3:0]        ram_wen;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [2:0]        starve_cnt_o;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .ram_en(ram_en), .ram_addr(ram_addr),
        .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .starve_cnt_o(starve_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        if_q[$];
    exp_t        mem_q[$];
    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic [31:0] last_if, last_mem;
    int          n_cmp, n_err, cyc, starve;
    bit          if_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bench RAM: synchronous read, byte-enabled write
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en) begin
            if (ram_wen != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wen[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram[ram_addr[9:2]];
            end
        end
    end

    // Monitor: pops expected responses when the DUT presents data
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (if_rvalid) begin
                if (if_q.size() == 0) chk("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
                else begin
                    e = if_q.pop_front();
                    chk("if_rdata", if_rdata, e.data);
                    chk("if_due", 32'(cyc), 32'(e.due));
                    last_if = e.data;
                end
            end else begin
                if (if_q.size() > 0 && if_q[0].due == cyc) begin
                    e = if_q.pop_front();
                    chk("if_rvalid_missing", 32'(if_rvalid), 32'd1);
                end
                chk("if_hold", if_rdata, last_if);
            end
            if (mem_rvalid) begin
                if (mem_q.size() == 0) chk("mem_rvalid_unexpected", 32'(mem_rvalid), 32'd0);
                else begin
                    e = mem_q.pop_front();
                    chk("mem_rdata", mem_rdata, e.data);
                    chk("mem_due", 32'(cyc), 32'(e.due));
                    last_mem = e.data;
                end
            end else begin
                if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
                    e = mem_q.pop_front();
                    chk("mem_rvalid_missing", 32'(mem_rvalid), 32'd1);
                end
                chk("mem_hold", mem_rdata, last_mem);
            end
        end
    end

    // Drive one cycle, check grants and RAM drive, push expected responses
    task automatic step(input bit ir, input logic [31:0] ia, input bit ic,
                        input bit mr, input logic [31:0] ma, input logic [3:0] mw,
                        input logic [31:0] md, output bit ig, output bit mg);
        exp_t e;
        @(posedge clk); #1;
        if_req = ir; if_addr = ia; if_cancel = ic;
        mem_req = mr; mem_addr = ma; mem_wen = mw; mem_wdata = md;
        if (ic && if_pending && if_q.size() > 0) void'(if_q.pop_back());
        #1;
        ig = ir && (!mr || (LIMIT != 0 && starve == LIMIT));
        mg = mr && !ig;
        chk("if_gnt", 32'(if_gnt), 32'(ig));
        chk("mem_gnt", 32'(mem_gnt), 32'(mg));
        chk("starve_cnt", 32'(starve_cnt_o), 32'(starve));
        chk("ram_en", 32'(ram_en), 32'(ig || mg));
        chk("ram_addr", ram_addr, ig ? ia : (mg ? ma : 32'd0));
        chk("ram_wen", 32'(ram_wen), mg ? 32'(mw) : 32'd0);
        chk("ram_wdata", ram_wdata, mg ? md : 32'd0);
        if (ig) begin
            e.data = ref_mem[ia[9:2]]; e.due = cyc + 1; if_q.push_back(e);
        end else if (mg) begin
            if (mw == 4'b0000) begin
                e.data = ref_mem[ma[9:2]]; e.due = cyc + 1; mem_q.push_back(e);
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mw[b]) ref_mem[ma[9:2]][8*b +: 8] = md[8*b +: 8];
            end
        end
        if_pending = ig;
        if (ir && !ig) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else starve = 0;
    endtask

    task automatic idle(input int n);
        bit ig, mg;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ig, mg);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'd0);
        chk({tag, "_mem_rvalid"}, 32'(mem_rvalid), 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_starve"}, 32'(starve_cnt_o), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
        chk({tag, "_gnts"}, 32'({if_gnt, mem_gnt}), 32'd0);
    endtask

    initial begin
        bit ig, mg, pend_if, pend_m;
        logic [31:0] pa, pma, pmd;
        logic [3:0]  pmw;
        n_cmp = 0; n_err = 0; cyc = 0; starve = 0; if_pending = 0;
        last_if = '0; last_mem = '0;
        resetn = 1'b0;
        if_req = 0; if_addr = '0; if_cancel = 0;
        mem_req = 0; mem_addr = '0; mem_wen = '0; mem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            ref_mem[i] = ram[i];
        end
        #3;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;

        // IF-only stream, then a MEM store
        for (int i = 0; i < 3; i++) step(1, 32'h100, 0, 0, 0, 0, 0, ig, mg);
        step(0, 0, 0, 1, 32'h204, 4'b1100, 32'hABCD0000, ig, mg);
        idle(2);
        // Contention: starvation override every fifth cycle
        for (int i = 0; i < 12; i++) step(1, 32'h80, 0, 1, 32'h300, 4'b0000, 0, ig, mg);
        idle(2);
        // Cancelled fetch leaves IF data unchanged
        step(1, 32'h40, 0, 0, 0, 0, 0, ig, mg);
        step(0, 0, 1, 0, 0, 0, 0, ig, mg);
        idle(1);
        // MEM load followed by IF fetch: no cross delivery
        step(0, 0, 0, 1, 32'h204, 4'b0000, 0, ig, mg);
        step(1, 32'h108, 0, 0, 0, 0, 0, ig, mg);
        idle(2);
        // Reset while an IF read is outstanding
        step(1, 32'h100, 0, 0, 0, 0, 0, ig, mg);
        @(posedge clk); #1;
        resetn = 1'b0;
        if_req = 0; if_cancel = 0; mem_req = 0; mem_wen = '0;
        if_q.delete(); mem_q.delete();
        if_pending = 0; starve = 0; last_if = '0; last_mem = '0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        resetn = 1'b1;
        idle(2);

        // Randomized traffic, requests held until granted
        pend_if = 0; pend_m = 0; pa = '0; pma = '0; pmw = '0; pmd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_if && ($urandom % 3 != 0)) begin
                pend_if = 1; pa = {22'd0, 8'($urandom), 2'b00};
            end
            if (!pend_m && ($urandom % 3 != 0)) begin
                pend_m = 1; pma = {22'd0, 8'($urandom), 2'b00};
                pmw = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
                pmd = $urandom;
            end
            step(pend_if, pend_if ? pa : 32'd0, ($urandom % 4 == 0),
                 pend_m, pend_m ? pma : 32'd0, pend_m ? pmw : 4'd0,
                 pend_m ? pmd : 32'd0, ig, mg);
            if (ig) pend_if = 0;
            if (mg) pend_m = 0;
        end
        idle(3);
        chk("if_q_drained", 32'(if_q.size()), 32'd0);
        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
